mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the RISC-V pipeline. Sits between the EX/MEM pipeline register and `mem_wb`. It converts the EX/MEM memory-control bits into requests on a req/gnt/rvalid data bus, generates byte enables, and sign- or zero-extends load data. It drives `read_data` into `mem_wb` and stalls the pipeline while a bus access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: data width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_mem_memread`  in  1  load in the MEM stage.
- `ex_mem_memwrite`  in  1  store in the MEM stage; wins if both are set.
- `ex_mem_funct3`  in  3  access size and sign.
- `result_ex_mem`  in  32  effective address from the ALU.
- `ex_mem_write_data`  in  32  store data (rs2).
- `read_data`  out  32  extended load result, consumed by `mem_wb`.
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and `mem_wb` while high.
- `misalign_exc`  out  1  one-cycle misalignment pulse.
- `dbus_req`  out  1  request valid.
- `dbus_we`  out  1  write request.
- `dbus_addr`  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- `dbus_be`  out  4  byte enables.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_gnt`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  read data valid; never earlier than the cycle after `dbus_gnt`.
- `dbus_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Access = `ex_mem_memread | ex_mem_memwrite`.
- IDLE:
  - Access and not trapped -> latch `dbus_addr`, `dbus_we`, `dbus_be`, `dbus_wdata`, offset and funct3; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `dbus_req`=1; all bus outputs held stable until `dbus_gnt`.
  - On `dbus_gnt`: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - On `dbus_rvalid`: register the extended `dbus_rdata` into `read_data`, then go to DONE.
- DONE:
  - `mem_stall`=0 for exactly one cycle so the pipeline advances; next state IDLE.
  - The same instruction is not re-issued.
- `mem_stall` = (IDLE & access & ~trap) | REQ | WAIT. It is combinational.
- Store lanes:
  - SB (000): be = 1<<off; wdata = byte replicated ×4.
  - SH (001): be = off[1] ? 1100 : 0011; wdata = half replicated ×2.
  - SW (010): be = 1111.
- Load extraction:
  - LB (000): sign-extend byte at off.
  - LH (001): sign-extend half at off[1].
  - LW (010): full word.
  - LBU (100): zero-extend byte at off.
  - LHU (101): zero-extend half at off[1].
- funct3 011/110/111 are treated as word access.
- `read_data` holds its value until the next load completes. Stores do not change it.
- Both `ex_mem_memread` and `ex_mem_memwrite` high: the access is a store.
- `dbus_rvalid` outside WAIT and `dbus_gnt` outside REQ are ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- `rst_n` low mid-access: `dbus_req` drops asynchronously and the access is abandoned. The bus side must tolerate this.
- Store with immediate grant: cycle0 IDLE (stall=1), cycle1 REQ+gnt, cycle2 DONE (stall=0). Minimum 3 cycles.
- Load: cycle1 REQ+gnt, cycle2 WAIT+rvalid, cycle3 DONE; `read_data` is valid from cycle3 onward. Minimum 4 cycles.
- Each gnt delay of N cycles and each rvalid delay of M cycles adds N/M cycles of stall.
- Non-memory instruction: zero added latency.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword access with off[0]=1, or a word access with off≠00, counts as trapped.
  - Trapped accesses issue no bus request and assert no stall.
  - `misalign_exc`=1 for the one IDLE cycle; `read_data` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Offset bits are forced aligned (word off=00, half off[0]=0).
  - `misalign_exc` is tied 0.

## Structure
- Package `riscv_mem_pkg` holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum `mau_state_t`.
- Sub-module `load_extend`: purely combinational extraction and extension (rdata, offset, funct3 -> 32-bit result), instantiated once.

## Test plan
- SW 0xDEADBEEF @0x100, gnt immediate -> dbus_be=1111, dbus_addr=0x100, stall 2 cycles, then DONE.
- SB 0x000000A5 @0x103 -> be=1000, wdata=0xA5A5A5A5.
- LB @0x102, rdata=0x0080FF00, gnt delayed 2, rvalid delayed 3 -> read_data=0xFFFFFF80; stall is high for exactly 7 cycles.
- LHU @0x102, rdata=0x8001_1234 -> read_data=0x00008001. LH of the same word -> 0xFFFF8001.
- LW @0x101: with MISALIGN_TRAP_EN -> misalign_exc=1 for one cycle, no dbus_req, stall=0. Without it -> dbus_addr=0x100, normal load.
- rst_n pulsed low while in WAIT -> dbus_req=0, stall=0, read_data=0 immediately; rvalid arriving after reset is ignored.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the memory-stage load/store unit:
//   - funct3 encodings for load/store size and signedness
//   - mau_state_t : load/store unit FSM state encoding
//   - access_size_t / access_size() : collapses funct3 into byte/half/word,
//     with the unused encodings 011/110/111 treated as word accesses
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mau_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  function automatic access_size_t access_size(input logic [2:0] funct3);
    access_size_t sz;
    case (funct3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend
// Purely combinational load-data extraction. Selects the byte or halfword
// addressed by the latched offset from the 32-bit bus word and sign- or
// zero-extends it according to funct3.
// Ports:
//   rdata  in  32  raw word from the data bus
//   offset in  2   byte offset within the word (already aligned for halves/words)
//   funct3 in  3   load size/sign encoding
//   result out 32  extended load value
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit. Turns the EX/MEM memory-control bits into a
// single req/gnt/rvalid bus transaction, builds byte enables and
// lane-replicated store data, extends load data into read_data, and holds
// mem_stall high while an access is outstanding.
//
// Build option: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are not issued; misalign_exc
//               pulses for the IDLE cycle the access is presented
//   undefined - offset bits are forced aligned; misalign_exc tied 0
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ex_mem_memread/memwrite    load / store in MEM (store wins if both)
//   ex_mem_funct3              access size and sign
//   result_ex_mem              effective address
//   ex_mem_write_data          store data
//   read_data                  extended load result to mem_wb
//   mem_stall                  pipeline freeze (combinational)
//   misalign_exc               misalignment pulse
//   dbus_req/we/addr/be/wdata  data bus request side
//   dbus_gnt/rvalid/rdata      data bus response side
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; a new access is latched here
// REQ   | dbus_req high, request fields held until dbus_gnt
// WAIT  | load granted, waiting for dbus_rvalid
// DONE  | access complete, stall released for one cycle
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic [2:0]        ex_mem_funct3,
  input  logic [31:0]       result_ex_mem,
  input  logic [DATA_W-1:0] ex_mem_write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_stall,
  output logic              misalign_exc,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata
);

  mau_state_t   state, state_next;
  access_size_t size;
  logic         access;
  logic         misaligned;
  logic         start;
  logic [1:0]   raw_off;
  logic [1:0]   off;
  logic [3:0]   be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [1:0]   off_q;
  logic [2:0]   funct3_q;
  logic [31:0]  ext_data;

  assign access  = ex_mem_memread | ex_mem_memwrite;
  assign size    = access_size(ex_mem_funct3);
  assign raw_off = result_ex_mem[1:0];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_HALF) && raw_off[0]) ||
                      ((size == SZ_WORD) && (raw_off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Aligned offset: with the trap enabled only aligned accesses get here, so
  // forcing alignment is a no-op; without it this is the silent fix-up.
  always_comb begin
    off        = raw_off;
    be_next    = 4'b1111;
    wdata_next = ex_mem_write_data;
    case (size)
      SZ_BYTE: begin
        off        = raw_off;
        be_next    = 4'b0001 << raw_off;
        wdata_next = {4{ex_mem_write_data[7:0]}};
      end
      SZ_HALF: begin
        off        = {raw_off[1], 1'b0};
        be_next    = raw_off[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{ex_mem_write_data[15:0]}};
      end
      default: begin
        off        = 2'b00;
        be_next    = 4'b1111;
        wdata_next = ex_mem_write_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    dbus_req     = 1'b0;
    mem_stall    = 1'b0;
    misalign_exc = 1'b0;
    start        = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            start      = 1'b1;
            mem_stall  = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        dbus_req  = 1'b1;
        mem_stall = 1'b1;
        if (dbus_gnt) begin
          state_next = dbus_we ? DONE : WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dbus_rvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields are captured once in IDLE so they stay stable through REQ
  // even if the EX/MEM inputs wiggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_addr  <= '0;
      dbus_we    <= 1'b0;
      dbus_be    <= 4'b0000;
      dbus_wdata <= '0;
      off_q      <= 2'b00;
      funct3_q   <= 3'b000;
    end else if (start) begin
      dbus_addr  <= {result_ex_mem[ADDR_W-1:2], 2'b00};
      dbus_we    <= ex_mem_memwrite;
      dbus_be    <= be_next;
      dbus_wdata <= wdata_next;
      off_q      <= off;
      funct3_q   <= ex_mem_funct3;
    end
  end

  load_extend u_load_extend (
    .rdata  (dbus_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if ((state == WAIT) && dbus_rvalid) begin
      read_data <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] result_ex_mem;
  logic [31:0] ex_mem_write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        misalign_exc;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_funct3     (ex_mem_funct3),
    .result_ex_mem     (result_ex_mem),
    .ex_mem_write_data (ex_mem_write_data),
    .read_data         (read_data),
    .mem_stall         (mem_stall),
    .misalign_exc      (misalign_exc),
    .dbus_req          (dbus_req),
    .dbus_we           (dbus_we),
    .dbus_addr         (dbus_addr),
    .dbus_be           (dbus_be),
    .dbus_wdata        (dbus_wdata),
    .dbus_gnt          (dbus_gnt),
    .dbus_rvalid       (dbus_rvalid),
    .dbus_rdata        (dbus_rdata)
  );

  // Bus responder + stall counter. Called at a negedge; returns at the
  // negedge after the stall drops. gnt_dly = extra REQ cycles before gnt;
  // rv_dly = cycles from gnt to rvalid (1 = earliest legal).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                            output int stalls, output logic [31:0] c_addr,
                            output logic [3:0] c_be, output logic [31:0] c_wdata,
                            output logic c_we, output logic timeout);
    int   req_n;
    int   wait_n;
    logic granted;
    stalls = 0; req_n = 0; wait_n = 0; granted = 1'b0; timeout = 1'b1;
    c_addr = '0; c_be = '0; c_wdata = '0; c_we = 1'b0;
    ex_mem_memread = rd; ex_mem_memwrite = wr; ex_mem_funct3 = f3;
    result_ex_mem = addr; ex_mem_write_data = wd;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!mem_stall) begin
        timeout = 1'b0;
        break;
      end
      stalls++;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
      if (dbus_req) begin
        c_addr = dbus_addr; c_be = dbus_be; c_wdata = dbus_wdata; c_we = dbus_we;
        if (req_n == gnt_dly) begin
          dbus_gnt = 1'b1;
          granted  = 1'b1;
        end
        req_n++;
      end else if (granted) begin
        if (wait_n == rv_dly - 1) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = rdata;
        end
        wait_n++;
      end
      @(negedge clk);
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; ex_mem_funct3 = 3'b000;
    result_ex_mem = '0; ex_mem_write_data = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    #3;
    total++; if (dbus_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dbus_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", misalign_exc); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", read_data); end
    total++; if ({dbus_we, dbus_be, dbus_addr, dbus_wdata} !== '0) begin
      bad++; $display("FAIL reset_bus: we=%b be=%b addr=%h wdata=%h want all 0", dbus_we, dbus_be, dbus_addr, dbus_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stores();
    int st; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; logic to;
    // SW immediate grant
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, '0, 0, 1, st, a, be, wd, we, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL sw_timeout: got %b want 0", to); end
    total++; if (st !== 2) begin bad++; $display("FAIL sw_stall: got %0d want 2", st); end
    total++; if (be !== 4'b1111) begin bad++; $display("FAIL sw_be: got %b want 1111", be); end
    total++; if (a !== 32'h100) begin bad++; $display("FAIL sw_addr: got %h want 00000100", a); end
    total++; if (wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", wd); end
    total++; if (we !== 1'b1) begin bad++; $display("FAIL sw_we: got %b want 1", we); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL sw_rdata_kept: got %h want 0", read_data); end
    // SB at byte 3
    run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, '0, 0, 1, st, a, be, wd, we, to);
    total++; if (be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", be); end
    total++; if (wd !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wd); end
    total++; if (a !== 32'h100) begin bad++; $display("FAIL sb_addr: got %h want 00000100", a); end
    // SH upper half, grant delayed by 1
    run_access(1'b0, 1'b1, 3'b001, 32'h106, 32'h1234BEEF, '0, 1, 1, st, a, be, wd, we, to);
    total++; if (be !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", be); end
    total++; if (wd !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata: got %h want beefbeef", wd); end
    total++; if (a !== 32'h104) begin bad++; $display("FAIL sh_addr: got %h want 00000104", a); end
    total++; if (st !== 3) begin bad++; $display("FAIL sh_stall: got %0d want 3", st); end
  endtask

  task automatic test_loads();
    int st; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; logic to;
    // LB with gnt 2 cycles late and rvalid 3 cycles after gnt: 1+3+3 stalls
    run_access(1'b1, 1'b0, 3'b000, 32'h102, '0, 32'h0080FF00, 2, 3, st, a, be, wd, we, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL lb_timeout: got %b want 0", to); end
    total++; if (st !== 7) begin bad++; $display("FAIL lb_stall: got %0d want 7", st); end
    total++; if (read_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", read_data); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL lb_we: got %b want 0", we); end
    run_access(1'b1, 1'b0, 3'b101, 32'h102, '0, 32'h80011234, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'h00008001) begin bad++; $display("FAIL lhu_data: got %h want 00008001", read_data); end
    total++; if (st !== 3) begin bad++; $display("FAIL lhu_stall: got %0d want 3", st); end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, '0, 32'h80011234, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data: got %h want ffff8001", read_data); end
    run_access(1'b1, 1'b0, 3'b100, 32'h101, '0, 32'h0000C300, 0, 2, st, a, be, wd, we, to);
    total++; if (read_data !== 32'h000000C3) begin bad++; $display("FAIL lbu_data: got %h want 000000c3", read_data); end
    total++; if (st !== 4) begin bad++; $display("FAIL lbu_stall: got %0d want 4", st); end
    // funct3 011 behaves as a word load
    run_access(1'b1, 1'b0, 3'b011, 32'h108, '0, 32'hCAFEF00D, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'hCAFEF00D) begin bad++; $display("FAIL f3_011_data: got %h want cafef00d", read_data); end
    total++; if (a !== 32'h108) begin bad++; $display("FAIL f3_011_addr: got %h want 00000108", a); end
  endtask

  task automatic test_misaligned();
`ifdef MISALIGN_TRAP_EN
    logic [31:0] prev;
    prev = read_data;
    ex_mem_memread = 1'b1; ex_mem_funct3 = 3'b010; result_ex_mem = 32'h101;
    #1;
    total++; if (misalign_exc !== 1'b1) begin bad++; $display("FAIL trap_exc: got %b want 1", misalign_exc); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL trap_stall: got %b want 0", mem_stall); end
    total++; if (dbus_req !== 1'b0) begin bad++; $display("FAIL trap_req: got %b want 0", dbus_req); end
    @(negedge clk);
    ex_mem_memread = 1'b0;
    #1;
    total++; if ({misalign_exc, dbus_req, mem_stall} !== 3'b000) begin
      bad++; $display("FAIL trap_after: exc/req/stall=%b want 000", {misalign_exc, dbus_req, mem_stall});
    end
    total++; if (read_data !== prev) begin bad++; $display("FAIL trap_rdata: got %h want %h", read_data, prev); end
    @(negedge clk);
`else
    int st; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; logic to;
    ex_mem_memread = 1'b1; ex_mem_funct3 = 3'b010; result_ex_mem = 32'h101;
    #1;
    total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL lw_mis_exc: got %b want 0", misalign_exc); end
    @(negedge clk);
    run_access(1'b1, 1'b0, 3'b010, 32'h101, '0, 32'h11223344, 0, 1, st, a, be, wd, we, to);
    total++; if (a !== 32'h100) begin bad++; $display("FAIL lw_mis_addr: got %h want 00000100", a); end
    total++; if (read_data !== 32'h11223344) begin bad++; $display("FAIL lw_mis_data: got %h want 11223344", read_data); end
    // misaligned LH is forced onto the lower half
    run_access(1'b1, 1'b0, 3'b001, 32'h101, '0, 32'h8001F234, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'hFFFFF234) begin bad++; $display("FAIL lh_mis_data: got %h want fffff234", read_data); end
`endif
  endtask

  task automatic test_both_set();
    int st; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; logic to;
    logic [31:0] prev;
    prev = read_data;
    run_access(1'b1, 1'b1, 3'b010, 32'h10C, 32'h00000055, 32'h77777777, 0, 1, st, a, be, wd, we, to);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL both_we: got %b want 1", we); end
    total++; if (st !== 2) begin bad++; $display("FAIL both_stall: got %0d want 2", st); end
    total++; if (read_data !== prev) begin bad++; $display("FAIL both_rdata: got %h want %h", read_data, prev); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we; logic to;
    run_access(1'b1, 1'b0, 3'b010, 32'h200, '0, 32'h13579BDF, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'h13579BDF) begin bad++; $display("FAIL b2b_lw: got %h want 13579bdf", read_data); end
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000003C, '0, 0, 1, st, a, be, wd, we, to);
    total++; if (be !== 4'b0010) begin bad++; $display("FAIL b2b_sb_be: got %b want 0010", be); end
    total++; if (wd !== 32'h3C3C3C3C) begin bad++; $display("FAIL b2b_sb_wdata: got %h want 3c3c3c3c", wd); end
    total++; if (read_data !== 32'h13579BDF) begin bad++; $display("FAIL b2b_rdata_kept: got %h want 13579bdf", read_data); end
    run_access(1'b1, 1'b0, 3'b000, 32'h203, '0, 32'h7F000000, 0, 1, st, a, be, wd, we, to);
    total++; if (read_data !== 32'h0000007F) begin bad++; $display("FAIL b2b_lb: got %h want 0000007f", read_data); end
  endtask

  task automatic test_nonmem();
    logic [31:0] prev;
    prev = read_data;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; result_ex_mem = 32'h300;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL nonmem_stall: got %b want 0", mem_stall); end
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (read_data !== prev) begin bad++; $display("FAIL stray_rvalid: got %h want %h", read_data, prev); end
    total++; if ({dbus_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL stray_gnt: req/stall=%b want 00", {dbus_req, mem_stall}); end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_midaccess();
    // reset while waiting for read data
    ex_mem_memread = 1'b1; ex_mem_funct3 = 3'b010; result_ex_mem = 32'h400;
    @(negedge clk);
    #1;
    dbus_gnt = 1'b1;
    @(negedge clk);
    #1;
    dbus_gnt = 1'b0;
    total++; if ({dbus_req, mem_stall} !== 2'b01) begin bad++; $display("FAIL wait_state: req/stall=%b want 01", {dbus_req, mem_stall}); end
    #1;
    ex_mem_memread = 1'b0; rst_n = 1'b0;
    #1;
    total++; if ({dbus_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL rst_wait_bus: req/stall=%b want 00", {dbus_req, mem_stall}); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_wait_rdata: got %h want 0", read_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    dbus_rvalid = 1'b0; dbus_rdata = '0;
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL late_rvalid: got %h want 0", read_data); end
    total++; if ({dbus_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL late_rvalid_idle: req/stall=%b want 00", {dbus_req, mem_stall}); end
    // reset while requesting: dbus_req must drop without a clock edge
    @(negedge clk);
    ex_mem_memread = 1'b1; ex_mem_funct3 = 3'b010; result_ex_mem = 32'h404;
    @(negedge clk);
    #1;
    total++; if (dbus_req !== 1'b1) begin bad++; $display("FAIL req_state: got %b want 1", dbus_req); end
    #1;
    ex_mem_memread = 1'b0; rst_n = 1'b0;
    #1;
    total++; if ({dbus_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL rst_req_bus: req/stall=%b want 00", {dbus_req, mem_stall}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_both_set();
    test_back_to_back();
    test_nonmem();
    test_reset_midaccess();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
